// File: rtl/mux2_out_fifo_pkg.sv
// mux2_out_fifo_pkg: shared defaults and sizing helper for the mux capture path
//   DATA_W_DEF : default mux word width
//   DEPTH_DEF  : default FIFO depth
//   clog2()    : ceiling log2 usable in parameter expressions
package mux2_out_fifo_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux2_fifo_mem.sv
// mux2_fifo_mem: DEPTH x W register file, one write port, one async read port
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read of mem[raddr_i]
module mux2_fifo_mem #(
  parameter int W = 5,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mux2_out_fifo.sv
// mux2_out_fifo: FIFO capture of tagged mux words with valid/ready drain and sticky overflow
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid_i/in_data_i/in_sel_i: mux word offered each cycle with its select tag
//   in_ready_o                   : space available (not full)
//   out_valid_o/out_data_o/out_sel_o : head entry, zeroed when empty
//   out_ready_i                  : consumer takes head
//   count_o, full_o, empty_o     : occupancy status
//   overflow_o, clear_ovf_i      : sticky dropped-word flag and its clear
module mux2_out_fifo
  import mux2_out_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sel_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  input  logic              clear_ovf_i
);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic push, pop;
  logic [DATA_W:0] head;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // full gates push regardless of a same-cycle pop, so a slot never opens early
  assign push = in_valid_i & ~full_o;
  assign pop = ~empty_o & out_ready_i;
  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // a new drop outranks clear so no event is lost
    ovf_d = (in_valid_i & full_o) | (ovf_q & ~clear_ovf_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  mux2_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we_i(push & ~rst),
    .waddr_i(wr_q[AW-1:0]),
    .wdata_i({in_sel_i, in_data_i}),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(head)
  );
  assign in_ready_o = ~full_o;
  assign out_valid_o = ~empty_o;
  assign out_data_o = empty_o ? '0 : head[DATA_W-1:0];
  assign out_sel_o = empty_o ? 1'b0 : head[DATA_W];
  assign count_o = count_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_mux2_out_fifo.sv
// tb_mux2_out_fifo: scoreboard bench with a queue-based reference model
module tb_mux2_out_fifo;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_sel = 0, out_ready = 0, clear_ovf = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, out_sel, full, empty, overflow;
  logic [3:0] out_data, count;
  int n_chk = 0, n_fail = 0;
  logic [4:0] exp_q[$];
  int mcnt = 0;
  logic movf = 0;
  bit mon_on = 0;
  always #5 clk = ~clk;
  mux2_out_fifo dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_sel_i(in_sel), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sel_o(out_sel), .out_ready_i(out_ready),
    .count_o(count), .full_o(full), .empty_o(empty), .overflow_o(overflow), .clear_ovf_i(clear_ovf)
  );
  function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, want, $time);
    end
  endfunction
  always @(negedge clk) if (mon_on) begin
    chk("count", 32'(count), 32'(mcnt));
    chk("empty", 32'(empty), 32'(mcnt == 0));
    chk("full", 32'(full), 32'(mcnt == 8));
    chk("in_ready", 32'(in_ready), 32'(mcnt < 8));
    chk("out_valid", 32'(out_valid), 32'(mcnt > 0));
    chk("overflow", 32'(overflow), 32'(movf));
    if (!out_valid) chk("idle_out", 32'({out_sel, out_data}), 32'(0));
    else if (out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'({out_sel, out_data}), 32'hdead);
      else chk("head_word", 32'({out_sel, out_data}), 32'(exp_q.pop_front()));
    end
  end
  task automatic step(input logic v, input logic [3:0] d, input logic s, input logic r,
                      input logic c, input logic rs);
    bit pu, po;
    in_valid = v; in_data = d; in_sel = s; out_ready = r; clear_ovf = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      mcnt = 0;
      movf = 0;
    end else begin
      pu = v && mcnt < 8;
      po = r && mcnt > 0;
      if (pu) exp_q.push_back({s, d});
      movf = (v && mcnt == 8) || (movf && !c);
      mcnt = mcnt + int'(pu) - int'(po);
    end
    #1;
    mon_on = 1;
  endtask
  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 0, 0, r, 0, 0);
  endtask
  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1, 4'(base + i), 1'((base + i) % 2), 0, 0, 0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(1, 0);
    step(1, 4'hA, 1, 0, 0, 0);
    idle(2, 0);
    idle(2, 1);
    fill(8, 0);
    idle(3, 1);
    fill(3, 8);
    idle(10, 1);
    fill(8, 0);
    step(1, 4'hF, 1, 0, 0, 0);
    idle(1, 0);
    idle(10, 1);
    step(0, 0, 0, 0, 1, 0);
    idle(1, 0);
    fill(3, 2);
    step(1, 4'h7, 1, 1, 0, 0);
    idle(1, 0);
    idle(5, 1);
    fill(8, 4);
    step(1, 4'h5, 0, 1, 0, 0);
    idle(1, 0);
    idle(9, 1);
    step(0, 0, 0, 0, 1, 0);
    fill(5, 1);
    step(1, 4'h9, 1, 1, 0, 1);
    idle(1, 0);
    fill(3, 12);
    idle(5, 1);
    for (int k = 0; k < 3000; k++) begin
      int ph;
      ph = (k / 200) % 3;
      step(1'($urandom_range(0, 99) < 75), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < (ph == 0 ? 20 : ph == 1 ? 50 : 90)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 299) == 0));
    end
    idle(12, 1);
    chk("drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
